// File: rtl/mem_wb_pkg.sv
// Shared definitions for the memory-access / MEM-WB stage: access-size codes,
// writeback-select codes, FSM states and the alignment rule.
package mem_wb_pkg;

  typedef enum logic [2:0] {
    DM_W  = 3'b000,
    DM_H  = 3'b001,
    DM_HU = 3'b010,
    DM_B  = 3'b011,
    DM_BU = 3'b100
  } dm_type_e;

  localparam logic [2:0] WD_ALU = 3'd0;
  localparam logic [2:0] WD_MEM = 3'd1;
  localparam logic [2:0] WD_PC4 = 3'd2;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  // Codes 101-111 fall into the word case.
  function automatic logic is_misaligned(input logic [2:0] dm, input logic [1:0] off);
    case (dm)
      DM_H, DM_HU: return off[0];
      DM_B, DM_BU: return 1'b0;
      default:     return off != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/mem_wb_stage_align.sv
// Store-lane replication / byte enables and load byte/half extraction with
// sign or zero extension, purely combinational.
module mem_align
  import mem_wb_pkg::*;
(
  input  logic [2:0]  dm_type,
  input  logic [1:0]  offset,
  input  logic [31:0] store_data,
  input  logic [31:0] load_word,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [31:0] shifted;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign shifted = load_word >> {offset, 3'b000};
  assign byte_v  = shifted[7:0];
  assign half_v  = offset[1] ? load_word[31:16] : load_word[15:0];

  always_comb begin
    be        = '1;
    wdata     = store_data;
    load_data = load_word;
    case (dm_type)
      DM_B, DM_BU: begin
        be        = 4'b0001 << offset;
        wdata     = {4{store_data[7:0]}};
        load_data = (dm_type == DM_B) ? {{24{byte_v[7]}}, byte_v} : {24'd0, byte_v};
      end
      DM_H, DM_HU: begin
        be        = offset[1] ? 4'b1100 : 4'b0011;
        wdata     = {2{store_data[15:0]}};
        load_data = (dm_type == DM_H) ? {{16{half_v[15]}}, half_v} : {16'd0, half_v};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// Memory-access stage: dmem req/ack FSM with timeout, pipeline stall generation
// and the MEM/WB pipeline register.
module mem_wb_stage
  import mem_wb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned TO_W    = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] EX_MEM_NPC,
  input  logic [31:0] EX_MEM_alu_result,
  input  logic [31:0] EX_MEM_read2_data,
  input  logic [4:0]  EX_MEM_RD,
  input  logic        EX_MEM_RegWrite,
  input  logic [2:0]  EX_MEM_WDSel,
  input  logic [2:0]  EX_MEM_DMType,
  input  logic        EX_MEM_MemRead,
  input  logic        EX_MEM_MemWrite,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        mem_stall,
  output logic        mem_exc,
  output logic [31:0] MEM_WB_NPC,
  output logic [31:0] MEM_WB_alu_result,
  output logic [31:0] MEM_WB_mem_data,
  output logic [4:0]  MEM_WB_RD,
  output logic        MEM_WB_RegWrite,
  output logic [2:0]  MEM_WB_WDSel
);

  state_e          state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic [31:0]     npc_q, npc_d, alu_q, alu_d, mdata_q, mdata_d;
  logic [4:0]      rd_q, rd_d;
  logic            rw_q, rw_d;
  logic [2:0]      wdsel_q, wdsel_d;

  logic        mem_op, misaligned, aligned_op, is_load;
  logic        req, abort, complete, stall, exc;
  logic [3:0]  be_w;
  logic [31:0] wdata_w, load_ext;

  mem_align u_align (
    .dm_type   (EX_MEM_DMType),
    .offset    (EX_MEM_alu_result[1:0]),
    .store_data(EX_MEM_read2_data),
    .load_word (dmem_rdata),
    .be        (be_w),
    .wdata     (wdata_w),
    .load_data (load_ext)
  );

  // Everything combinational is masked by rst_n so outputs read 0 during reset.
  always_comb begin
    mem_op     = EX_MEM_MemRead | EX_MEM_MemWrite;
    misaligned = mem_op & is_misaligned(EX_MEM_DMType, EX_MEM_alu_result[1:0]);
    aligned_op = mem_op & ~misaligned;
    is_load    = EX_MEM_MemRead & ~EX_MEM_MemWrite;
    req        = rst_n & ((state_q == WAIT) | aligned_op);
    abort      = rst_n & (state_q == WAIT) & ~dmem_ack & (cnt_q == TO_W'(TIMEOUT - 1));
    complete   = req & dmem_ack;
    stall      = rst_n & aligned_op & ~dmem_ack & ~abort;
    exc        = rst_n & (misaligned | abort);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The counter counts request cycles including the IDLE issue cycle, so it
  // enters WAIT at 1 and the stall lasts TIMEOUT-1 cycles before the abort.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (req && !dmem_ack) begin
        state_d = WAIT;
        cnt_d   = TO_W'(1);
      end
      WAIT: if (dmem_ack || abort) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + TO_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    dmem_req   = req;
    dmem_we    = req & EX_MEM_MemWrite;
    dmem_addr  = req ? {EX_MEM_alu_result[31:2], 2'b00} : '0;
    dmem_be    = req ? be_w : '0;
    dmem_wdata = req ? wdata_w : '0;
    mem_stall  = stall;
    mem_exc    = exc;
  end

  always_comb begin
    npc_d   = npc_q;
    alu_d   = alu_q;
    mdata_d = mdata_q;
    rd_d    = rd_q;
    rw_d    = rw_q;
    wdsel_d = wdsel_q;
    if (stall) begin
      rd_d = '0;
      rw_d = 1'b0;
    end else begin
      npc_d   = EX_MEM_NPC;
      alu_d   = EX_MEM_alu_result;
      mdata_d = (complete && is_load) ? load_ext : '0;
      rd_d    = EX_MEM_RD;
      rw_d    = EX_MEM_RegWrite & ~exc;
      wdsel_d = EX_MEM_WDSel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      npc_q   <= '0;
      alu_q   <= '0;
      mdata_q <= '0;
      rd_q    <= '0;
      rw_q    <= 1'b0;
      wdsel_q <= '0;
    end else begin
      npc_q   <= npc_d;
      alu_q   <= alu_d;
      mdata_q <= mdata_d;
      rd_q    <= rd_d;
      rw_q    <= rw_d;
      wdsel_q <= wdsel_d;
    end
  end

  assign MEM_WB_NPC        = npc_q;
  assign MEM_WB_alu_result = alu_q;
  assign MEM_WB_mem_data   = mdata_q;
  assign MEM_WB_RD         = rd_q;
  assign MEM_WB_RegWrite   = rw_q;
  assign MEM_WB_WDSel      = wdsel_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: the driver queues the expected MEM/WB
// record per instruction, the monitor pops one at every non-stall edge.
module tb_mem_wb_stage;
  import mem_wb_pkg::*;

  localparam int unsigned TIMEOUT = 16;

  logic        clk, rst_n;
  logic [31:0] ex_npc, ex_alu, ex_d;
  logic [4:0]  ex_rd;
  logic        ex_rw, ex_mr, ex_mw;
  logic [2:0]  ex_wdsel, ex_dm;
  logic        dmem_req, dmem_we, dmem_ack, mem_stall, mem_exc;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic [31:0] wb_npc, wb_alu, wb_mdata;
  logic [4:0]  wb_rd;
  logic        wb_rw;
  logic [2:0]  wb_wdsel;

  int n_tests = 0;
  int n_fail  = 0;

  mem_wb_stage #(.TIMEOUT(TIMEOUT), .TO_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .EX_MEM_NPC(ex_npc), .EX_MEM_alu_result(ex_alu), .EX_MEM_read2_data(ex_d),
    .EX_MEM_RD(ex_rd), .EX_MEM_RegWrite(ex_rw), .EX_MEM_WDSel(ex_wdsel),
    .EX_MEM_DMType(ex_dm), .EX_MEM_MemRead(ex_mr), .EX_MEM_MemWrite(ex_mw),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .mem_stall(mem_stall), .mem_exc(mem_exc),
    .MEM_WB_NPC(wb_npc), .MEM_WB_alu_result(wb_alu), .MEM_WB_mem_data(wb_mdata),
    .MEM_WB_RD(wb_rd), .MEM_WB_RegWrite(wb_rw), .MEM_WB_WDSel(wb_wdsel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] npc, alu, d, rdata;
    logic [4:0]  rd;
    logic        rw, mr, mw;
    logic [2:0]  wdsel, dm;
  } instr_t;

  typedef struct {
    logic [31:0] npc, alu, mem_data, addr, wdata;
    logic [4:0]  rd;
    logic        rw, req, we, lanes;
    logic [2:0]  wdsel;
    logic [3:0]  be;
    int          stalls, exc;
  } exp_t;

  exp_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic instr_t mk(input logic [31:0] npc, alu, d, rdata, input logic [4:0] rd,
                                input logic rw, input logic [2:0] wdsel, dm, input logic mr, mw);
    instr_t i;
    i.npc = npc; i.alu = alu; i.d = d; i.rdata = rdata; i.rd = rd;
    i.rw = rw; i.wdsel = wdsel; i.dm = dm; i.mr = mr; i.mw = mw;
    return i;
  endfunction

  task automatic drive(input instr_t i);
    ex_npc = i.npc; ex_alu = i.alu; ex_d = i.d; ex_rd = i.rd; ex_rw = i.rw;
    ex_wdsel = i.wdsel; ex_dm = i.dm; ex_mr = i.mr; ex_mw = i.mw; dmem_rdata = i.rdata;
  endtask

  // ack_delay: number of stall cycles before ack (-1 = never)
  task automatic issue(input instr_t i, input logic [31:0] md, input logic rw, input int stalls,
                       input logic req, input int exc, input logic [3:0] be,
                       input logic [31:0] wd, input int ack_delay);
    exp_t e;
    @(negedge clk);
    rst_n = 1'b1;
    drive(i);
    dmem_ack = (ack_delay == 0);
    e.npc = i.npc; e.alu = i.alu; e.rd = i.rd; e.wdsel = i.wdsel;
    e.mem_data = md; e.rw = rw; e.stalls = stalls; e.req = req; e.exc = exc;
    e.we = i.mw; e.addr = {i.alu[31:2], 2'b00};
    e.lanes = i.mw & req; e.be = be; e.wdata = wd;
    exp_q.push_back(e);
    for (int c = 1; c <= stalls; c++) begin
      @(negedge clk);
      dmem_ack = (c == ack_delay);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req"}, dmem_req, 0);   chk({tag, "_we"}, dmem_we, 0);
    chk({tag, "_addr"}, dmem_addr, 0); chk({tag, "_be"}, dmem_be, 0);
    chk({tag, "_wdata"}, dmem_wdata, 0);
    chk({tag, "_stall"}, mem_stall, 0); chk({tag, "_exc"}, mem_exc, 0);
    chk({tag, "_npc"}, wb_npc, 0);     chk({tag, "_alu"}, wb_alu, 0);
    chk({tag, "_mdata"}, wb_mdata, 0); chk({tag, "_rd"}, wb_rd, 0);
    chk({tag, "_rw"}, wb_rw, 0);       chk({tag, "_wdsel"}, wb_wdsel, 0);
  endtask

  // Monitor: samples request/stall/exc just before each edge, checks just after.
  initial begin
    int st = 0;
    int exc_n = 0;
    logic req_seen = 1'b0;
    logic we_s = 1'b0;
    logic [31:0] addr_s = '0, wdata_s = '0;
    logic [3:0]  be_s = '0;
    logic in_rst, stalled;
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      in_rst  = !rst_n;
      stalled = mem_stall;
      if (mem_exc) exc_n++;
      if (dmem_req) begin
        req_seen = 1'b1; we_s = dmem_we; addr_s = dmem_addr; be_s = dmem_be; wdata_s = dmem_wdata;
      end
      @(posedge clk);
      #1;
      if (in_rst) begin
        st = 0; exc_n = 0; req_seen = 1'b0;
      end else if (stalled) begin
        chk("bubble_rw", wb_rw, 0);
        chk("bubble_rd", wb_rd, 0);
        st++;
      end else if (exp_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_output: MEM_WB update with no pending instruction at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        chk("wb_npc", wb_npc, e.npc);
        chk("wb_alu", wb_alu, e.alu);
        chk("wb_mem_data", wb_mdata, e.mem_data);
        chk("wb_rd", wb_rd, e.rd);
        chk("wb_regwrite", wb_rw, e.rw);
        chk("wb_wdsel", wb_wdsel, e.wdsel);
        chk("stall_cycles", st, e.stalls);
        chk("exc_pulses", exc_n, e.exc);
        chk("req_seen", req_seen, e.req);
        if (e.req) begin
          chk("dmem_addr", addr_s, e.addr);
          chk("dmem_we", we_s, e.we);
        end
        if (e.lanes) begin
          chk("dmem_be", be_s, e.be);
          chk("dmem_wdata", wdata_s, e.wdata);
        end
        st = 0; exc_n = 0; req_seen = 1'b0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    instr_t nop;
    nop = mk(0, 0, 0, 0, 0, 0, WD_ALU, DM_W, 0, 0);
    rst_n = 1'b1; drive(nop); dmem_ack = 1'b0;
    #1 rst_n = 1'b0;
    #1 chk_all_zero("reset");

    issue(nop, 0, 0, 0, 0, 0, 0, 0, -1);
    // ALU op: one-cycle pass-through, no request
    issue(mk(32'h8, 32'h1234, 0, 0, 5, 1, WD_ALU, DM_W, 0, 0), 0, 1, 0, 0, 0, 0, 0, -1);
    // LB at offset 3, ack after 3 stall cycles
    issue(mk(32'hC, 32'h103, 0, 32'h80FF_FFFF, 7, 1, WD_MEM, DM_B, 1, 0),
          32'hFFFF_FF80, 1, 3, 1, 0, 0, 0, 3);
    // SH upper half, same-cycle ack
    issue(mk(32'h10, 32'h102, 32'hABCD_1234, 0, 0, 0, WD_ALU, DM_H, 0, 1),
          0, 0, 0, 1, 0, 4'b1100, 32'h1234_1234, 0);
    // misaligned LW
    issue(mk(32'h14, 32'h101, 0, 0, 9, 1, WD_MEM, DM_W, 1, 0), 0, 0, 0, 0, 1, 0, 0, -1);
    // LHU with no ack: timeout abort
    issue(mk(32'h18, 32'h202, 0, 32'h1111_2222, 10, 1, WD_MEM, DM_HU, 1, 0),
          0, 0, TIMEOUT - 1, 1, 1, 0, 0, -1);
    // LH upper half, sign-extended
    issue(mk(32'h1C, 32'h206, 0, 32'h8001_7FFF, 11, 1, WD_MEM, DM_H, 1, 0),
          32'hFFFF_8001, 1, 1, 1, 0, 0, 0, 1);
    // LBU byte 1, zero-extended
    issue(mk(32'h20, 32'h301, 0, 32'h1234_5678, 12, 1, WD_MEM, DM_BU, 1, 0),
          32'h0000_0056, 1, 0, 1, 0, 0, 0, 0);
    // SB byte 2
    issue(mk(32'h24, 32'h2, 32'h0000_00A5, 0, 0, 0, WD_ALU, DM_B, 0, 1),
          0, 0, 0, 1, 0, 4'b0100, 32'hA5A5_A5A5, 0);
    // SW with 2-cycle latency
    issue(mk(32'h28, 32'h10, 32'hDEAD_BEEF, 0, 0, 0, WD_ALU, DM_W, 0, 1),
          0, 0, 2, 1, 0, 4'b1111, 32'hDEAD_BEEF, 2);
    // MemRead and MemWrite both set: a store, no load data
    issue(mk(32'h2C, 32'h20, 32'h1122_3344, 32'h5566_7788, 13, 1, WD_PC4, DM_W, 1, 1),
          0, 1, 0, 1, 0, 4'b1111, 32'h1122_3344, 0);
    // undefined DMType 101 acts as word: misaligned at offset 2
    issue(mk(32'h30, 32'h22, 0, 0, 14, 1, WD_MEM, 3'b101, 1, 0), 0, 0, 0, 0, 1, 0, 0, -1);
    // undefined DMType 111 aligned: full word
    issue(mk(32'h34, 32'h40, 0, 32'hCAFE_F00D, 15, 1, WD_MEM, 3'b111, 1, 0),
          32'hCAFE_F00D, 1, 0, 1, 0, 0, 0, 0);

    // reset asserted while an LW waits for ack
    @(negedge clk);
    drive(mk(32'h38, 32'h44, 0, 32'h7777_7777, 3, 1, WD_MEM, DM_W, 1, 0));
    dmem_ack = 1'b0;
    @(negedge clk);
    #1 chk("wait_req_before_reset", dmem_req, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1 chk_all_zero("midwait_reset");
    // release with pipeline flushed and a late ack: nothing registers
    issue(nop, 0, 0, 0, 0, 0, 0, 0, 0);
    issue(mk(32'h3C, 32'h5678, 0, 0, 6, 1, WD_ALU, DM_W, 0, 0), 0, 1, 0, 0, 0, 0, 0, -1);

    @(posedge clk);
    #3;
    chk("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
